// File: rtl/execute_mc.sv
// Handshaked Y86 execute stage: computes valE, condition codes and cnd for one
// instruction at a time, with an iterative shift-add multiplier for OPQ ifun 4.
module execute_mc #(
  parameter int         XLEN   = 64,
  parameter bit         MUL_EN = 1'b1,
  parameter logic [2:0] CC_RST = 3'b001
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      icode_i,
  input  logic [3:0]      ifun_i,
  input  logic [XLEN-1:0] vala_i,
  input  logic [XLEN-1:0] valb_i,
  input  logic [XLEN-1:0] valc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] vale_o,
  output logic            cnd_o,
  output logic [2:0]      cc_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);

  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   vale_q;
  logic              cnd_q;
  logic [2:0]        cc_q;
  logic [XLEN-1:0]   mcand_q, mplier_q, acc_q;
  logic [CW-1:0]     cnt_q;

  logic              accept;
  logic              is_mul;
  logic              mul_last;
  logic [XLEN-1:0]   acc_sum;
  logic [XLEN-1:0]   alu_val;
  logic              alu_of;
  logic              cc_we;
  logic              cnd_eval;

  assign is_mul   = MUL_EN && (icode_i == I_OPQ) && (ifun_i == 4'd4);
  assign accept   = in_valid_i && in_ready_o;
  assign mul_last = (cnt_q == CW'(XLEN - 1));
  assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    in_ready_o = 1'b0;
    state_d    = state_q;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = is_mul ? CALC : DONE;
      end
      CALC: begin
        if (mul_last) state_d = DONE;
      end
      DONE: begin
        in_ready_o = out_ready_i;
        if (out_ready_i) begin
          if (in_valid_i) state_d = is_mul ? CALC : DONE;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_val = '0;
    alu_of  = 1'b0;
    cc_we   = 1'b0;
    case (icode_i)
      I_IRMOVQ:           alu_val = valc_i;
      I_RMMOVQ, I_MRMOVQ: alu_val = valb_i + valc_i;
      I_CMOVXX:           alu_val = vala_i;
      I_CALL, I_PUSHQ:    alu_val = valb_i - XLEN'(8);
      I_RET, I_POPQ:      alu_val = valb_i + XLEN'(8);
      I_OPQ: begin
        cc_we = 1'b1;
        case (ifun_i)
          4'd1: begin
            alu_val = valb_i - vala_i;
            alu_of  = (valb_i[XLEN-1] != vala_i[XLEN-1]) &&
                      (alu_val[XLEN-1] != valb_i[XLEN-1]);
          end
          4'd2: alu_val = valb_i & vala_i;
          4'd3: alu_val = valb_i ^ vala_i;
          default: begin
            alu_val = valb_i + vala_i;
            alu_of  = (valb_i[XLEN-1] == vala_i[XLEN-1]) &&
                      (alu_val[XLEN-1] != vala_i[XLEN-1]);
          end
        endcase
      end
      default: alu_val = '0;
    endcase
  end

  // cnd always sees the flags as they stand before this instruction executes
  always_comb begin
    cnd_eval = 1'b0;
    case (ifun_i)
      4'd0: cnd_eval = 1'b1;
      4'd1: cnd_eval = (cc_q[1] ^ cc_q[2]) | cc_q[0];
      4'd2: cnd_eval = cc_q[1] ^ cc_q[2];
      4'd3: cnd_eval = cc_q[0];
      4'd4: cnd_eval = ~cc_q[0];
      4'd5: cnd_eval = ~(cc_q[1] ^ cc_q[2]);
      4'd6: cnd_eval = ~(cc_q[1] ^ cc_q[2]) & ~cc_q[0];
      default: cnd_eval = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      vale_q   <= '0;
      cnd_q    <= 1'b0;
      cc_q     <= CC_RST;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnd_q <= cnd_eval;
        if (is_mul) begin
          mcand_q  <= vala_i;
          mplier_q <= valb_i;
          acc_q    <= '0;
          cnt_q    <= '0;
        end else begin
          vale_q <= alu_val;
          if (cc_we) cc_q <= {alu_of, alu_val[XLEN-1], alu_val == '0};
        end
      end
      // One multiplier bit per cycle; the final iteration writes the result directly
      if (state_q == CALC) begin
        acc_q    <= acc_sum;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
        if (mul_last) begin
          vale_q <= acc_sum;
          cc_q   <= {1'b0, acc_sum[XLEN-1], acc_sum == '0};
        end
      end
    end
  end

  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q == CALC);
  assign vale_o      = vale_q;
  assign cnd_o       = cnd_q;
  assign cc_o        = cc_q;

endmodule

// File: tb/tb_execute_mc.sv
// Self-checking bench for execute_mc: directed scenarios plus a reference-model
// scoreboard that predicts valE/cnd for every accepted instruction.
module tb_execute_mc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  icode_i;
  logic [3:0]  ifun_i;
  logic [63:0] vala_i, valb_i, valc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] vale_o;
  logic        cnd_o;
  logic [2:0]  cc_o;
  logic        busy_o;

  typedef struct {
    logic [63:0] vale;
    logic        cnd;
  } exp_t;

  exp_t        sb[$];
  logic [2:0]  model_cc = 3'b001;
  int          checks   = 0;
  int          failures = 0;

  execute_mc #(.XLEN(64), .MUL_EN(1'b1), .CC_RST(3'b001)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .icode_i(icode_i), .ifun_i(ifun_i),
    .vala_i(vala_i), .valb_i(valb_i), .valc_i(valc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .vale_o(vale_o), .cnd_o(cnd_o), .cc_o(cc_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] model_vale(input logic [3:0] ic, input logic [3:0] fn,
                                              input logic [63:0] a, input logic [63:0] b,
                                              input logic [63:0] c);
    case (ic)
      4'h2:        return a;
      4'h3:        return c;
      4'h4, 4'h5:  return b + c;
      4'h8, 4'hA:  return b - 64'd8;
      4'h9, 4'hB:  return b + 64'd8;
      4'h6: begin
        case (fn)
          4'd1:    return b - a;
          4'd2:    return b & a;
          4'd3:    return b ^ a;
          4'd4:    return b * a;
          default: return b + a;
        endcase
      end
      default:     return 64'd0;
    endcase
  endfunction

  function automatic logic model_cnd(input logic [3:0] fn, input logic [2:0] cc);
    logic of, sf, zf;
    {of, sf, zf} = cc;
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return (sf ^ of) | zf;
      4'd2:    return sf ^ of;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return !(sf ^ of);
      4'd6:    return !(sf ^ of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard: pop on every output handshake, push on every input handshake
  always @(negedge clk_i) begin
    exp_t e;
    logic [63:0] r;
    logic of;
    if (rst_i) begin
      sb.delete();
      model_cc = 3'b001;
    end else begin
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("sb_vale", vale_o, e.vale);
          checkOutput("sb_cnd", {63'd0, cnd_o}, {63'd0, e.cnd});
        end
      end
      if (in_valid_i && in_ready_o) begin
        r      = model_vale(icode_i, ifun_i, vala_i, valb_i, valc_i);
        e.vale = r;
        e.cnd  = model_cnd(ifun_i, model_cc);
        sb.push_back(e);
        if (icode_i == 4'h6) begin
          case (ifun_i)
            4'd1:             of = (valb_i[63] != vala_i[63]) && (r[63] != valb_i[63]);
            4'd2, 4'd3, 4'd4: of = 1'b0;
            default:          of = (valb_i[63] == vala_i[63]) && (r[63] != vala_i[63]);
          endcase
          model_cc = {of, r[63], r == 64'd0};
        end
      end
    end
  end

  // Offer one instruction and return just after the edge on which it was accepted
  task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] fn,
                               input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    bit accepted = 1'b0;
    icode_i    = ic;
    ifun_i     = fn;
    vala_i     = a;
    valb_i     = b;
    valc_i     = c;
    in_valid_i = 1'b1;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk_i);
      if (in_ready_o) accepted = 1'b1;
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cycles, ready_viol, latency, hold_viol, stray_valid;
    bit seen;
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    icode_i     = 4'h1;
    ifun_i      = 4'h0;
    vala_i      = '0;
    valb_i      = '0;
    valc_i      = '0;

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    checkOutput("rst_cc", {61'd0, cc_o}, 64'd1);
    checkOutput("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
    checkOutput("rst_busy", {63'd0, busy_o}, 64'd0);
    checkOutput("rst_vale", vale_o, 64'd0);
    checkOutput("rst_cnd", {63'd0, cnd_o}, 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    applyStimulus(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    checkOutput("add_ovf_valid", {63'd0, out_valid_o}, 64'd1);
    checkOutput("add_ovf_vale", vale_o, 64'h8000_0000_0000_0000);
    checkOutput("add_ovf_cc", {61'd0, cc_o}, 64'b110);
    applyStimulus(4'h7, 4'h2, 64'd0, 64'd0, 64'h40);
    checkOutput("jl_cnd", {63'd0, cnd_o}, 64'd0);

    applyStimulus(4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
    checkOutput("sub_zero_vale", vale_o, 64'd0);
    checkOutput("sub_zero_cc", {61'd0, cc_o}, 64'b001);
    applyStimulus(4'h2, 4'h3, 64'h1234, 64'd0, 64'd0);
    checkOutput("cmove_vale", vale_o, 64'h1234);
    checkOutput("cmove_cnd", {63'd0, cnd_o}, 64'd1);
    @(posedge clk_i);
    #1;

    applyStimulus(4'h6, 4'h4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0);
    busy_cycles = 0;
    ready_viol  = 0;
    latency     = 0;
    seen        = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_i);
      latency++;
      if (busy_o) begin
        busy_cycles++;
        if (in_ready_o) ready_viol++;
      end
      if (out_valid_o) seen = 1'b1;
    end
    checkOutput("mul_seen", {63'd0, seen}, 64'd1);
    checkOutput("mul_busy_cycles", 64'(busy_cycles), 64'd64);
    checkOutput("mul_ready_in_calc", 64'(ready_viol), 64'd0);
    checkOutput("mul_latency", 64'(latency), 64'd65);
    checkOutput("mul_vale", vale_o, 64'hFFFF_FFFF_FFFF_FFEB);
    checkOutput("mul_of", {63'd0, cc_o[2]}, 64'd0);
    checkOutput("mul_sf", {63'd0, cc_o[1]}, 64'd1);
    @(posedge clk_i);
    #1;

    out_ready_i = 1'b0;
    applyStimulus(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
    hold_viol = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (vale_o !== 64'hF8 || in_ready_o !== 1'b0 || out_valid_o !== 1'b1) hold_viol++;
    end
    checkOutput("bp_hold", 64'(hold_viol), 64'd0);
    checkOutput("bp_vale", vale_o, 64'hF8);
    @(posedge clk_i);
    #1;
    icode_i     = 4'h3;
    ifun_i      = 4'h0;
    valc_i      = 64'd9;
    valb_i      = 64'd0;
    vala_i      = 64'd0;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("bp_release_ready", {63'd0, in_ready_o}, 64'd1);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    checkOutput("bp_next_vale", vale_o, 64'd9);
    checkOutput("bp_next_valid", {63'd0, out_valid_o}, 64'd1);
    @(posedge clk_i);
    #1;

    applyStimulus(4'h6, 4'h4, 64'd6, 64'd5, 64'd0);
    repeat (10) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checkOutput("midrst_valid", {63'd0, out_valid_o}, 64'd0);
    checkOutput("midrst_cc", {61'd0, cc_o}, 64'b001);
    checkOutput("midrst_busy", {63'd0, busy_o}, 64'd0);
    stray_valid = 0;
    repeat (80) begin
      @(negedge clk_i);
      if (out_valid_o) stray_valid++;
    end
    checkOutput("midrst_no_output", 64'(stray_valid), 64'd0);
    @(posedge clk_i);
    #1;
    applyStimulus(4'h6, 4'h0, 64'd3, 64'd2, 64'd0);
    checkOutput("post_rst_add", vale_o, 64'd5);

    for (int n = 0; n < 16; n++) begin
      logic [3:0] ic;
      ic = 4'($urandom_range(0, 15));
      applyStimulus(ic, 4'($urandom_range(0, 7)),
                    (n % 3 == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom},
                    (n % 2 == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom},
                    {$urandom, $urandom});
    end

    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk_i);
      if (sb.size() == 0 && !out_valid_o) seen = 1'b1;
    end
    checkOutput("drain_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
